// File: rtl/branch_predictor.sv
// branch_predictor
//   Direct-mapped branch target buffer with a saturating direction counter per
//   entry. Prediction is a combinational lookup on the fetch PC; training comes
//   from execute and lands on the next rising edge. Two wrapping perf counters
//   track resolved control-flow updates and mispredicts.
//
// Ports
//   i_clk             clock, all state changes on rising edge
//   i_rst             synchronous active-high reset
//   i_fetch_pc        PC being fetched
//   o_pred_hit        valid entry with matching tag
//   o_pred_taken      predicted taken
//   o_pred_target     predicted next PC (target or fetch PC + 4)
//   i_flush           invalidate every entry
//   i_upd_valid       resolution result present this cycle
//   i_upd_pc          PC of the resolved instruction
//   i_upd_taken       actual direction
//   i_upd_target      actual target
//   i_upd_jump        unconditional jump (JAL/JALR)
//   i_upd_mispredict  execute saw a direction or target mismatch
//   o_upd_count       resolved-update count (wraps)
//   o_mispred_count   mispredict count (wraps)
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_fetch_pc,
  output logic            o_pred_hit,
  output logic            o_pred_taken,
  output logic [XLEN-1:0] o_pred_target,
  input  logic            i_flush,
  input  logic            i_upd_valid,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic            i_upd_taken,
  input  logic [XLEN-1:0] i_upd_target,
  input  logic            i_upd_jump,
  input  logic            i_upd_mispredict,
  output logic [31:0]     o_upd_count,
  output logic [31:0]     o_mispred_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [CNT_W-1:0] cnt_q    [ENTRIES];
  logic             jump_q   [ENTRIES];

  logic [31:0] upd_count_q, upd_count_d;
  logic [31:0] mispred_count_q, mispred_count_d;

  // Low PC bits never select an entry; fold them away so lint stays quiet.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{i_fetch_pc[1:0], i_upd_pc[1:0]};

  // Lookup
  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;

  assign fetch_idx     = i_fetch_pc[IDX_W+1:2];
  assign fetch_tag     = i_fetch_pc[XLEN-1:IDX_W+2];
  assign o_pred_hit    = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign o_pred_taken  = o_pred_hit && (jump_q[fetch_idx] || cnt_q[fetch_idx][CNT_W-1]);
  assign o_pred_target = o_pred_taken ? target_q[fetch_idx] : i_fetch_pc + XLEN'(4);

  // Training: compute the new contents of the single entry being touched.
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             ent_we;
  logic             ent_valid_d;
  logic [TAG_W-1:0] ent_tag_d;
  logic [XLEN-1:0]  ent_target_d;
  logic [CNT_W-1:0] ent_cnt_d;
  logic             ent_jump_d;

  assign upd_idx = i_upd_pc[IDX_W+1:2];
  assign upd_tag = i_upd_pc[XLEN-1:IDX_W+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    ent_we       = 1'b0;
    ent_valid_d  = valid_q[upd_idx];
    ent_tag_d    = tag_q[upd_idx];
    ent_target_d = target_q[upd_idx];
    ent_cnt_d    = cnt_q[upd_idx];
    ent_jump_d   = jump_q[upd_idx];
    if (i_upd_valid) begin
      if (upd_hit) begin
        ent_we     = 1'b1;
        ent_jump_d = i_upd_jump;
        if (i_upd_taken) begin
          ent_target_d = i_upd_target;
          if (cnt_q[upd_idx] != CNT_MAX) ent_cnt_d = cnt_q[upd_idx] + CNT_W'(1);
        end else begin
          if (cnt_q[upd_idx] != '0) ent_cnt_d = cnt_q[upd_idx] - CNT_W'(1);
        end
      end else if (i_upd_taken) begin
        // Allocation on a taken miss evicts whatever aliased here.
        ent_we       = 1'b1;
        ent_valid_d  = 1'b1;
        ent_tag_d    = upd_tag;
        ent_target_d = i_upd_target;
        ent_cnt_d    = CNT_WEAK;
        ent_jump_d   = i_upd_jump;
      end
    end
  end

  assign upd_count_d     = upd_count_q + {31'd0, i_upd_valid};
  assign mispred_count_d = mispred_count_q + {31'd0, i_upd_valid & i_upd_mispredict};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= '0;
        jump_q[i]   <= 1'b0;
      end
      upd_count_q     <= '0;
      mispred_count_q <= '0;
    end else begin
      if (ent_we) begin
        valid_q[upd_idx]  <= ent_valid_d;
        tag_q[upd_idx]    <= ent_tag_d;
        target_q[upd_idx] <= ent_target_d;
        cnt_q[upd_idx]    <= ent_cnt_d;
        jump_q[upd_idx]   <= ent_jump_d;
      end
      // Placed after the entry write so a same-cycle flush leaves it invalid.
      if (i_flush) begin
        for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
      end
      upd_count_q     <= upd_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign o_upd_count     = upd_count_q;
  assign o_mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        flush;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_jump;
  logic        upd_mispredict;
  logic [31:0] upd_count;
  logic [31:0] mispred_count;

  branch_predictor #(.XLEN(32), .ENTRIES(64), .CNT_W(2)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_fetch_pc       (fetch_pc),
    .o_pred_hit       (pred_hit),
    .o_pred_taken     (pred_taken),
    .o_pred_target    (pred_target),
    .i_flush          (flush),
    .i_upd_valid      (upd_valid),
    .i_upd_pc         (upd_pc),
    .i_upd_taken      (upd_taken),
    .i_upd_target     (upd_target),
    .i_upd_jump       (upd_jump),
    .i_upd_mispredict (upd_mispredict),
    .o_upd_count      (upd_count),
    .o_mispred_count  (mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic [31:0] upd_cnt;
    logic [31:0] mis_cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] m_upd = 32'd0;
  logic [31:0] m_mis = 32'd0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: compares the combinational prediction and counters mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ".hit"},    {31'd0, pred_hit},   {31'd0, e.hit});
      check({e.name, ".taken"},  {31'd0, pred_taken}, {31'd0, e.taken});
      check({e.name, ".target"}, pred_target,         e.target);
      check({e.name, ".updcnt"}, upd_count,           e.upd_cnt);
      check({e.name, ".miscnt"}, mispred_count,       e.mis_cnt);
    end
  end

  // One cycle: drive inputs just after the rising edge, queue the expected
  // prediction for this cycle, advance the counter model, move to next edge.
  task automatic cyc(input string nm, input logic [31:0] fpc,
                     input logic eh, input logic et, input logic [31:0] etg,
                     input logic uv, input logic [31:0] upc, input logic utk,
                     input logic [31:0] utg, input logic uj, input logic um,
                     input logic fl, input logic rs);
    exp_t e;
    fetch_pc       = fpc;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_taken      = utk;
    upd_target     = utg;
    upd_jump       = uj;
    upd_mispredict = um;
    flush          = fl;
    rst            = rs;
    e.name    = nm;
    e.hit     = eh;
    e.taken   = et;
    e.target  = etg;
    e.upd_cnt = m_upd;
    e.mis_cnt = m_mis;
    sb.push_back(e);
    if (rs) begin
      m_upd = 32'd0;
      m_mis = 32'd0;
    end else if (uv) begin
      m_upd = m_upd + 32'd1;
      if (um) m_mis = m_mis + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; fetch_pc = 32'h0;
    upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0; upd_target = 32'h0;
    upd_jump = 1'b0; upd_mispredict = 1'b0;
    @(posedge clk);
    #1;

    // Conditional branch at 0x100; the training cycle itself still sees a miss.
    cyc("reset_pred", 32'h100, 0,0,32'h104, 1,32'h100,1,32'h200,0,1, 0,0);
    cyc("alloc",      32'h100, 1,1,32'h200, 1,32'h100,0,32'h0,  0,1, 0,0);
    cyc("dec_to1",    32'h100, 1,0,32'h104, 1,32'h100,1,32'h200,0,0, 0,0);
    cyc("inc_to2",    32'h100, 1,1,32'h200, 1,32'h100,1,32'h200,0,0, 0,0);
    cyc("inc_to3",    32'h100, 1,1,32'h200, 1,32'h100,1,32'h200,0,0, 0,0);
    cyc("sat_hi_a",   32'h100, 1,1,32'h200, 1,32'h100,1,32'h200,0,0, 0,0);
    cyc("sat_hi_b",   32'h100, 1,1,32'h200, 1,32'h100,0,32'h0,  0,0, 0,0);
    cyc("dec_to2",    32'h100, 1,1,32'h200, 1,32'h100,0,32'h0,  0,0, 0,0);
    cyc("dec_to1b",   32'h100, 1,0,32'h104, 1,32'h100,0,32'h0,  0,0, 0,0);
    cyc("dec_to0",    32'h100, 1,0,32'h104, 1,32'h100,0,32'h0,  0,0, 0,0);
    cyc("sat_lo",     32'h100, 1,0,32'h104, 0,32'h0,  0,32'h0,  0,0, 0,0);

    // Jump at 0x40: jump bit keeps it taken even as the counter drains.
    cyc("jal_miss",   32'h40, 0,0,32'h44, 1,32'h40,1,32'h80,1,0, 0,0);
    for (int i = 0; i < 5; i++)
      cyc("jal_hold", 32'h40, 1,1,32'h80, 1,32'h40,0,32'h0, 1,0, 0,0);
    cyc("jal_last",   32'h40, 1,1,32'h80, 1,32'h40,0,32'h0, 0,0, 0,0);
    cyc("jal_clear",  32'h40, 1,0,32'h44, 0,32'h0, 0,32'h0, 0,0, 0,0);

    // Aliasing: 0x100, 0x200 and 0x300 share index 0.
    cyc("alias_tr1",  32'h100, 1,0,32'h104, 1,32'h100,1,32'h200,0,0, 0,0);
    cyc("alias_tr2",  32'h100, 1,0,32'h104, 1,32'h100,1,32'h200,0,0, 0,0);
    cyc("alias_own",  32'h100, 1,1,32'h200, 1,32'h200,1,32'h300,0,1, 0,0);
    cyc("alias_evct", 32'h100, 0,0,32'h104, 1,32'h300,0,32'h0,  0,0, 0,0);
    cyc("alias_new",  32'h200, 1,1,32'h300, 0,32'h0,  0,32'h0,  0,0, 0,0);
    cyc("alias_nt",   32'h300, 0,0,32'h304, 0,32'h0,  0,32'h0,  0,0, 0,0);

    // Flush wins over a same-cycle update and still counts it.
    cyc("flush_upd",  32'h200, 1,1,32'h300, 1,32'h200,1,32'h300,0,0, 1,0);
    cyc("flush_inv",  32'h200, 0,0,32'h204, 0,32'h0,  0,32'h0,  0,0, 0,0);
    cyc("flush_jal",  32'h40,  0,0,32'h44,  1,32'h200,1,32'h340,0,0, 0,0);
    cyc("refill",     32'h200, 1,1,32'h340, 0,32'h0,  0,32'h0,  0,0, 0,0);

    // Reset mid-training discards entries and counters.
    cyc("mid_rst",    32'h200, 1,1,32'h340, 1,32'h200,1,32'h400,0,1, 0,1);
    cyc("post_rst",   32'h200, 0,0,32'h204, 0,32'h0,  0,32'h0,  0,0, 0,0);

    // Ten not-taken misses, three flagged mispredicts.
    for (int i = 1; i <= 10; i++)
      cyc("perf_run", 32'h100, 0,0,32'h104, 1,32'h500,0,32'h0,0,
          (i == 2 || i == 5 || i == 9), 0,0);
    if (m_upd != 32'd10 || m_mis != 32'd3) begin
      n_fail++;
      $display("FAIL perf_model: model %0d/%0d, required 10/3", m_upd, m_mis);
    end
    cyc("perf_10_3",  32'h500, 0,0,32'h504, 0,32'h0,0,32'h0,0,0, 0,0);

    // Preload the update counter to all ones, then wrap it.
    force dut.upd_count_q = 32'hFFFF_FFFF;
    m_upd = 32'hFFFF_FFFF;
    cyc("preload",    32'h100, 0,0,32'h104, 0,32'h0,0,32'h0,0,0, 0,0);
    release dut.upd_count_q;
    cyc("wrap_pre",   32'h100, 0,0,32'h104, 1,32'h500,0,32'h0,0,0, 0,0);
    cyc("wrap_zero",  32'h100, 0,0,32'h104, 0,32'h0,0,32'h0,0,0, 0,0);

    @(negedge clk);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
